slave_port_v3: RTL and testbench



---
 rtl/slave_port_v3_if.sv | 21 ++
 rtl/slave_port_v3.sv | 156 +++++++++++++++
 tb/tb_slave_port_v3.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/slave_port_v3_if.sv
// rtl/slave_port_v3_if.sv - serial bus handshake bundle between a master and slave_port_v3
interface slave_port_v3_if;
  logic mode;
  logic wr_bus;
  logic master_valid;
  logic master_ready;
  logic rd_bus;
  logic slave_ready;
  logic slave_valid;
  logic addr_err;

  modport master (
    output mode, wr_bus, master_valid, master_ready,
    input  rd_bus, slave_ready, slave_valid, addr_err
  );

  modport slave (
    input  mode, wr_bus, master_valid, master_ready,
    output rd_bus, slave_ready, slave_valid, addr_err
  );
endinterface

// File: rtl/slave_port_v3.sv
// rtl/slave_port_v3.sv - bit-serial bus slave with local register memory (option: SLAVE_PORT_ADDR_DECODE_EN)
module slave_port_v3 #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 64,
  parameter int BASE_ADDR  = 0
) (
  input logic           clk,
  input logic           resetn,
  slave_port_v3_if.slave bus
);

  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int AX_W  = ADDR_WIDTH + 1;
  // The first address bit is taken in IDLE, so ADDR sees ADDR_WIDTH-1 beats.
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'((ADDR_WIDTH >= 2) ? ADDR_WIDTH - 2 : 0);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WRITE,
    S_RLOAD,
    S_RSEND
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rsh_q, rsh_d;
  logic                    mode_q, mode_d;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
  logic                    in_range;
  logic [IDX_W-1:0]        mem_idx;
  logic                    in_beat;
  logic                    out_beat;

  assign in_beat  = bus.master_valid & bus.slave_ready;
  assign out_beat = bus.slave_valid & bus.master_ready;

`ifdef SLAVE_PORT_ADDR_DECODE_EN
  logic [AX_W-1:0] offset;
  assign offset   = {1'b0, addr_q} - AX_W'(BASE_ADDR);
  assign in_range = ({1'b0, addr_q} >= AX_W'(BASE_ADDR)) && (offset < AX_W'(MEM_DEPTH));
  assign mem_idx  = offset[IDX_W-1:0];
  assign bus.addr_err = ((state_q == S_WRITE) || (state_q == S_RLOAD)) && !in_range;
`else
  // Without decode the low address bits index memory and higher bits alias.
  logic unused_cfg;
  assign unused_cfg   = ^{addr_q, 32'(BASE_ADDR)};
  assign in_range     = 1'b1;
  assign mem_idx      = addr_q[IDX_W-1:0];
  assign bus.addr_err = 1'b0;
`endif

  assign bus.slave_ready = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_WDATA);
  assign bus.slave_valid = (state_q == S_RSEND);
  assign bus.rd_bus      = (state_q == S_RSEND) ? rsh_q[DATA_WIDTH-1] : 1'b0;

  // Next-state logic: frame sequencing, serial shifting and bit counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rsh_d   = rsh_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (in_beat) begin
          addr_d = ADDR_WIDTH'(bus.wr_bus);
          mode_d = bus.mode;
          cnt_d  = '0;
          if (ADDR_WIDTH == 1) state_d = bus.mode ? S_WDATA : S_RLOAD;
          else                 state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (in_beat) begin
          addr_d = (addr_q << 1) | ADDR_WIDTH'(bus.wr_bus);
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = mode_q ? S_WDATA : S_RLOAD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WDATA: begin
        if (in_beat) begin
          wdata_d = (wdata_q << 1) | DATA_WIDTH'(bus.wr_bus);
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = S_WRITE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      S_RLOAD: begin
        rsh_d   = in_range ? mem[mem_idx] : '1;
        state_d = S_RSEND;
      end
      S_RSEND: begin
        if (out_beat) begin
          rsh_d = rsh_q << 1;
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and shift registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rsh_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rsh_q   <= rsh_d;
      mode_q  <= mode_d;
    end
  end

  // Register memory: written at the end of WRITE, never reset.
  always_ff @(posedge clk) begin
    if ((state_q == S_WRITE) && in_range) begin
      mem[mem_idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_slave_port_v3.sv
// tb/tb_slave_port_v3.sv - self-checking bench for slave_port_v3 with a behavioural memory model
module tb_slave_port_v3;

  localparam int          AW    = 16;
  localparam int          DW    = 8;
  localparam int          DEPTH = 64;
  localparam logic [15:0] BASE  = 16'h1000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  slave_port_v3_if bus ();

  slave_port_v3 #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEM_DEPTH (DEPTH),
    .BASE_ADDR (int'(BASE))
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int         checks = 0;
  int         failures = 0;
  int         err_pulses = 0;
  logic [7:0] mdl [DEPTH];

  // Count addr_err cycles half a period away from the active edge.
  always @(negedge clk) if (resetn && bus.addr_err === 1'b1) err_pulses++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_in_range(input logic [15:0] a);
`ifdef SLAVE_PORT_ADDR_DECODE_EN
    return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + DEPTH);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int m_idx(input logic [15:0] a);
`ifdef SLAVE_PORT_ADDR_DECODE_EN
    return int'(a) - int'(BASE);
`else
    return int'(a) % DEPTH;
`endif
  endfunction

  function automatic int m_err(input logic [15:0] a);
`ifdef SLAVE_PORT_ADDR_DECODE_EN
    return m_in_range(a) ? 0 : 1;
`else
    return 0;
`endif
  endfunction

  function automatic logic [7:0] exp_rd(input logic [15:0] a);
    return m_in_range(a) ? mdl[m_idx(a)] : 8'hFF;
  endfunction

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One input beat; waits (bounded) for slave_ready, then presents the bit for one edge.
  task automatic send_bit(input logic b, input logic m);
    int guard = 0;
    while (bus.slave_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 50) check("ready_timeout", bus.slave_ready, 1);
    bus.mode = m;
    bus.wr_bus = b;
    bus.master_valid = 1'b1;
    @(posedge clk); #1;
    bus.master_valid = 1'b0;
    bus.mode = 1'($urandom);
    bus.wr_bus = 1'($urandom);
  endtask

  task automatic write_frame(input logic [15:0] a, input logic [7:0] d, input int stall_after, input bit gaps);
    int e0 = err_pulses;
    for (int i = AW - 1; i >= 0; i--) begin
      send_bit(a[i], (i == AW - 1) ? 1'b1 : 1'($urandom));
      if (AW - i == stall_after) idle_cycles(3);
      else if (gaps && $urandom_range(3) == 0) idle_cycles($urandom_range(2, 1));
    end
    for (int i = DW - 1; i >= 0; i--) send_bit(d[i], 1'($urandom));
    check("wr_ready_low", bus.slave_ready, 0);
    @(posedge clk); #1;
    check("wr_ready_back", bus.slave_ready, 1);
    check("wr_addr_err", err_pulses - e0, m_err(a));
    if (m_in_range(a)) mdl[m_idx(a)] = d;
  endtask

  task automatic read_frame(input logic [15:0] a, input int stall_bit, input bit gaps, output logic [7:0] d);
    int   e0 = err_pulses;
    logic held;
    for (int i = AW - 1; i >= 0; i--) begin
      send_bit(a[i], (i == AW - 1) ? 1'b0 : 1'($urandom));
      if (i != 0 && gaps && $urandom_range(3) == 0) idle_cycles($urandom_range(2, 1));
    end
    check("rload_valid_low", bus.slave_valid, 0);
    @(posedge clk); #1;
    bus.master_ready = 1'b1;
    for (int k = 0; k < DW; k++) begin
      check("rsend_valid", bus.slave_valid, 1);
      if (k == stall_bit) begin
        bus.master_ready = 1'b0;
        held = bus.rd_bus;
        repeat (4) begin
          @(posedge clk); #1;
          check("stall_hold_bit", bus.rd_bus, held);
          check("stall_hold_valid", bus.slave_valid, 1);
        end
        bus.master_ready = 1'b1;
      end
      d[DW-1-k] = bus.rd_bus;
      @(posedge clk); #1;
    end
    bus.master_ready = 1'b0;
    check("rd_done_valid", bus.slave_valid, 0);
    check("rd_done_ready", bus.slave_ready, 1);
    check("rd_addr_err", err_pulses - e0, m_err(a));
  endtask

  initial begin
    logic [7:0]  d;
    logic [15:0] a;
    logic [7:0]  wd;

    bus.mode = 1'b0;
    bus.wr_bus = 1'b0;
    bus.master_valid = 1'b0;
    bus.master_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_slave_ready", bus.slave_ready, 1);
    check("rst_slave_valid", bus.slave_valid, 0);
    check("rst_rd_bus", bus.rd_bus, 0);
    check("rst_addr_err", bus.addr_err, 0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    // Give every word a known value
    for (int i = 0; i < DEPTH; i++) write_frame(BASE + 16'(i), 8'($urandom), -1, 1'b0);

    // Write 0xA5 then read it back bit by bit
    write_frame(BASE + 16'd5, 8'hA5, -1, 1'b0);
    read_frame(BASE + 16'd5, -1, 1'b0, d);
    check("tp_a5_model", d, exp_rd(BASE + 16'd5));
    check("tp_a5_literal", d, 8'hA5);

    // Input stall after address bit 7
    write_frame(BASE + 16'd3, 8'h3C, 7, 1'b0);
    read_frame(BASE + 16'd3, -1, 1'b0, d);
    check("tp_stall_wr", d, 8'h3C);

    // Output stall during the 3rd read bit
    read_frame(BASE + 16'd3, 2, 1'b0, d);
    check("tp_stall_rd", d, 8'h3C);

    // Reset after 10 address beats of a write frame
    a = BASE + 16'd7;
    for (int i = AW - 1; i >= AW - 10; i--) send_bit(a[i], (i == AW - 1) ? 1'b1 : 1'b0);
    resetn = 1'b0;
    #1;
    check("midrst_slave_ready", bus.slave_ready, 1);
    check("midrst_slave_valid", bus.slave_valid, 0);
    check("midrst_rd_bus", bus.rd_bus, 0);
    check("midrst_addr_err", bus.addr_err, 0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    wd = 8'($urandom);
    write_frame(BASE + 16'd9, wd, -1, 1'b0);
    read_frame(BASE + 16'd9, -1, 1'b0, d);
    check("post_rst_new", d, exp_rd(BASE + 16'd9));
    read_frame(BASE + 16'd7, -1, 1'b0, d);
    check("post_rst_untouched", d, exp_rd(BASE + 16'd7));

    // Address 0x0005 relative to BASE 0x1000
    write_frame(16'h0005, 8'hFF, -1, 1'b0);
    read_frame(BASE + 16'd5, -1, 1'b0, d);
    check("base_word5", d, exp_rd(BASE + 16'd5));
    read_frame(16'h0005, -1, 1'b0, d);
    check("base_low_read", d, 8'hFF);

    // Randomised frames with mode noise, gaps and stalls
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(3))
        0, 1: a = BASE + 16'($urandom_range(DEPTH - 1));
        2:    a = 16'($urandom);
        default: begin
          case ($urandom_range(3))
            0: a = BASE - 16'd1;
            1: a = BASE;
            2: a = BASE + 16'(DEPTH - 1);
            default: a = BASE + 16'(DEPTH);
          endcase
        end
      endcase
      if ($urandom_range(1) == 1) begin
        write_frame(a, 8'($urandom), ($urandom_range(3) == 0) ? $urandom_range(15, 1) : -1, 1'b1);
      end else begin
        read_frame(a, ($urandom_range(2) == 0) ? $urandom_range(DW - 1) : -1, 1'b1, d);
        check("rand_read", d, exp_rd(a));
      end
    end

    // Final sweep of the whole memory
    for (int i = 0; i < DEPTH; i++) begin
      read_frame(BASE + 16'(i), -1, 1'b0, d);
      check("sweep_read", d, exp_rd(BASE + 16'(i)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
